// File: rtl/aes_round_sequencer_if.sv
// Handshake/data bundle between crypto issue logic, key storage and aes_round_sequencer.
// The optional abort input (AES_ABORT_EN) is a plain port on the sequencer, not part of this bundle.
interface aes_round_sequencer_if #(
  parameter int N = 127
);
  logic       start;
  logic       ready;
  logic [N:0] data_in;
  logic       key_req;
  logic [3:0] key_idx;
  logic       key_valid;
  logic [N:0] key_data;
  logic       busy;
  logic       done;
  logic [N:0] data_out;

  // Sequencer side.
  modport slave (
    input  start, data_in, key_valid, key_data,
    output ready, key_req, key_idx, busy, done, data_out
  );

  // Issue logic / key storage side.
  modport master (
    output start, data_in, key_valid, key_data,
    input  ready, key_req, key_idx, busy, done, data_out
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: one round per accepted round key, one shared state register.
// Optional feature: define AES_ABORT_EN to add an abort input that cancels an operation in FETCH.
module aes_round_sequencer #(
  parameter int N  = 127,
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef AES_ABORT_EN
  input  logic                 abort,
`endif
  aes_round_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE
  } state_e;

  typedef logic [N:0] blk_t;

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_e     state_q, state_d;
  blk_t       st_q, st_d;
  logic [3:0] rnd_q, rnd_d;
  blk_t       data_out_q, data_out_d;
  blk_t       sr_out, mc_out, ark_in;
  logic       abort_hit;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic, reduction polynomial 0x11B
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 via a short square-and-multiply chain; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x;
    x = gf_mul(a, a);        // a^2
    x = gf_mul(x, a);        // a^3
    x = gf_mul(x, x);        // a^6
    x = gf_mul(x, a);        // a^7
    x = gf_mul(x, x);        // a^14
    x = gf_mul(x, a);        // a^15
    x = gf_mul(x, x);        // a^30
    x = gf_mul(x, a);        // a^31
    x = gf_mul(x, x);        // a^62
    x = gf_mul(x, a);        // a^63
    x = gf_mul(x, x);        // a^126
    x = gf_mul(x, a);        // a^127
    return gf_mul(x, x);     // a^254
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // ---------------------------------------------------------------------------
  // Round stages. Byte i of a block lives at [N-8i -: 8]; byte index = row + 4*column.
  // ---------------------------------------------------------------------------
  function automatic blk_t sub_bytes(input blk_t s);
    blk_t r;
    for (int i = 0; i < 16; i++) r[N-8*i -: 8] = sbox(s[N-8*i -: 8]);
    return r;
  endfunction

  function automatic blk_t shift_rows(input blk_t s);
    blk_t r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[N-8*(row+4*c) -: 8] = s[N-8*(row+4*((c+row)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic blk_t mix_columns(input blk_t s);
    blk_t       r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[N-32*c    -: 8];
      a1 = s[N-32*c-8  -: 8];
      a2 = s[N-32*c-16 -: 8];
      a3 = s[N-32*c-24 -: 8];
      r[N-32*c    -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[N-32*c-8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[N-32*c-16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[N-32*c-24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // Single datapath instance shared by every round.
  assign sr_out = shift_rows(sub_bytes(st_q));
  assign mc_out = mix_columns(sr_out);

`ifdef AES_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    st_d       = st_q;
    rnd_d      = rnd_q;
    data_out_d = data_out_q;
    ark_in     = mc_out;

    if (rnd_q == 4'd0)          ark_in = st_q;
    else if (rnd_q == LAST_RND) ark_in = sr_out;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          st_d    = bus.data_in;
          rnd_d   = 4'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort_hit) begin
          state_d = S_IDLE;
        end else if (bus.key_valid) begin
          st_d = ark_in ^ bus.key_data;
          if (rnd_q == LAST_RND) begin
            data_out_d = st_d;
            state_d    = S_DONE;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: st_q is a plain register, not a RAM, so it is reset with everything else.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      st_q       <= '0;
      rnd_q      <= 4'd0;
      data_out_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
      state_q    <= state_d;
      st_q       <= st_d;
      rnd_q      <= rnd_d;
      data_out_q <= data_out_d;
    end
  end

  // Outputs depend only on flops; nothing combinational from inputs reaches them.
  assign bus.ready    = (state_q == S_IDLE);
  assign bus.key_req  = (state_q == S_FETCH);
  assign bus.key_idx  = (state_q == S_FETCH) ? rnd_q : 4'd0;
  assign bus.busy     = (state_q == S_FETCH) || (state_q == S_DONE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: FIPS-197 vector, stalls, start spam, reset, stray keys, abort.
// Reference model works on byte arrays with plain polynomial arithmetic and an inverse-search S-box.
module tb_aes_round_sequencer;

  logic clk;
  logic rst_n;
`ifdef AES_ABORT_EN
  logic abort;
`endif

  aes_round_sequencer_if #(.N(127)) bus ();

  aes_round_sequencer #(.N(127), .NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef AES_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  int          checks;
  int          errors;
  logic [7:0]  sbox_tbl [256];
  logic [127:0] rk [11];
  int          stall [11];
  logic [127:0] last_ct;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] m_mul(input int unsigned a, input int unsigned b);
    int unsigned p;
    p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int i = 14; i >= 8; i--) if (((p >> i) & 1) != 0) p = p ^ (32'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic void build_sbox();
    logic [7:0] b;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (m_mul(32'(x), 32'(y)) == 8'h01) b = 8'(y);
      s = 8'h63;
      for (int i = 0; i < 8; i++) s[i] = s[i] ^ b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8];
      sbox_tbl[x] = s;
    end
  endfunction

  function automatic void expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = m_mul(32'd2, 32'(rc));
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
    logic [7:0]   a [16];
    logic [7:0]   t [16];
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) a[i] = sbox_tbl[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[row+4*c] = a[row+4*((c+row)%4)];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          if (r < 10)
            a[row+4*c] = m_mul(32'd2, 32'(t[row+4*c])) ^ m_mul(32'd3, 32'(t[(row+1)%4+4*c]))
                       ^ t[(row+2)%4+4*c] ^ t[(row+3)%4+4*c];
          else
            a[row+4*c] = t[row+4*c];
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = a[i];
      s = s ^ rk[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    128'(bus.ready),    128'd1);
    check({tag, "_key_req"},  128'(bus.key_req),  128'd0);
    check({tag, "_key_idx"},  128'(bus.key_idx),  128'd0);
    check({tag, "_busy"},     128'(bus.busy),     128'd0);
    check({tag, "_done"},     128'(bus.done),     128'd0);
    check({tag, "_data_out"}, bus.data_out,       128'd0);
  endtask

  // One operation, entered and left at a negedge with the DUT expected in IDLE.
  // Key storage uses rk[]; stall[k] cycles of key_valid=0 are inserted on key index k.
  task automatic run_op(input logic [127:0] pt, input logic [127:0] exp, input bit spam,
                        input int abort_idx, input int rst_cyc);
    int cyc;
    int exp_idx;
    int total_stall;
    int left [11];
    total_stall = 0;
    for (int k = 0; k < 11; k++) begin
      left[k] = stall[k];
      total_stall += stall[k];
    end
    check("ready_before_start", 128'(bus.ready), 128'd1);
    check("data_out_held", bus.data_out, last_ct);
    bus.start   = 1'b1;
    bus.data_in = pt;
    exp_idx     = 0;
    cyc         = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (spam) begin
        bus.start   = 1'b1;
        bus.data_in = rand128();
      end else begin
        bus.start = 1'b0;
      end
      if (cyc > 80) begin
        checks++;
        errors++;
        $error("FAIL done_timeout: no done after %0d cycles", cyc);
        bus.start     = 1'b0;
        bus.key_valid = 1'b0;
        return;
      end
      if (cyc == rst_cyc) begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.key_valid = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check("reset_no_done", 128'(bus.done), 128'd0);
        end
        rst_n   = 1'b1;
        last_ct = '0;
        return;
      end
      if (bus.done) begin
        check("done_cycle", 128'(cyc), 128'(12 + total_stall));
        check("ciphertext", bus.data_out, exp);
        check("busy_in_done", 128'(bus.busy), 128'd1);
        check("ready_in_done", 128'(bus.ready), 128'd0);
        check("key_req_in_done", 128'(bus.key_req), 128'd0);
        last_ct       = exp;
        bus.key_valid = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 128'(bus.done), 128'd0);
        check("ready_after_done", 128'(bus.ready), 128'd1);
        check("data_out_after_done", bus.data_out, exp);
        if (!spam) bus.start = 1'b0;
        return;
      end
      check("key_req_fetch", 128'(bus.key_req), 128'd1);
      check("busy_fetch", 128'(bus.busy), 128'd1);
      check("ready_fetch", 128'(bus.ready), 128'd0);
      check("key_idx", 128'(bus.key_idx), 128'(exp_idx));
      if (exp_idx > 10) begin
        checks++;
        errors++;
        $error("FAIL extra_fetch: still fetching after key 10 (cycle %0d)", cyc);
        bus.key_valid = 1'b0;
        continue;
      end
      bus.key_data = rk[exp_idx];
`ifdef AES_ABORT_EN
      if (exp_idx == abort_idx) begin
        abort         = 1'b1;
        bus.key_valid = 1'b1;
        @(negedge clk);
        abort         = 1'b0;
        bus.key_valid = 1'b0;
        bus.start     = 1'b0;
        check("abort_ready", 128'(bus.ready), 128'd1);
        check("abort_key_req", 128'(bus.key_req), 128'd0);
        check("abort_no_done", 128'(bus.done), 128'd0);
        check("abort_data_out", bus.data_out, last_ct);
        return;
      end
`endif
      if (left[exp_idx] > 0) begin
        bus.key_valid = 1'b0;
        left[exp_idx]--;
      end else begin
        bus.key_valid = 1'b1;
        exp_idx++;
      end
    end
  endtask

  task automatic random_run(input int abort_idx, input int rst_cyc);
    logic [127:0] pt;
    pt = rand128();
    expand_key(rand128());
    run_op(pt, model_encrypt(pt), 1'b0, abort_idx, rst_cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [127:0] fips_pt;
    logic [127:0] fips_key;
    logic [127:0] fips_ct;
    logic [127:0] pt;
    checks   = 0;
    errors   = 0;
    last_ct  = '0;
    fips_key = 128'h000102030405060708090a0b0c0d0e0f;
    fips_pt  = 128'h00112233445566778899aabbccddeeff;
    fips_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    for (int k = 0; k < 11; k++) stall[k] = 0;
    build_sbox();

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.data_in   = '0;
    bus.key_valid = 1'b0;
    bus.key_data  = '0;
`ifdef AES_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // FIPS-197 C.1 with key_valid tied high.
    expand_key(fips_key);
    run_op(fips_pt, fips_ct, 1'b0, -1, -1);

    // Same vector, 3-cycle stalls on key indices 0, 5 and 10.
    stall[0]  = 3;
    stall[5]  = 3;
    stall[10] = 3;
    run_op(fips_pt, fips_ct, 1'b0, -1, -1);
    for (int k = 0; k < 11; k++) stall[k] = 0;

    // Start held high throughout; the follow-up start lands in the first ready cycle.
    pt = rand128();
    expand_key(rand128());
    run_op(pt, model_encrypt(pt), 1'b1, -1, -1);
    random_run(-1, -1);

    // Reset in cycle 6 of an operation, then a clean run.
    random_run(-1, 6);
    random_run(-1, -1);

    // Stray key_valid in IDLE.
    for (int k = 0; k < 5; k++) begin
      bus.key_valid = 1'b1;
      bus.key_data  = rand128();
      @(negedge clk);
      check("stray_key_req", 128'(bus.key_req), 128'd0);
      check("stray_ready", 128'(bus.ready), 128'd1);
      check("stray_busy", 128'(bus.busy), 128'd0);
    end
    bus.key_valid = 1'b0;
    random_run(-1, -1);

`ifdef AES_ABORT_EN
    random_run(4, -1);
    random_run(-1, -1);
`endif

    // Random plaintext/keys with random stall patterns.
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 11; k++) stall[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      random_run(-1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
